// File: rtl/ts_ci_arb.sv
// Two-source TS packet arbiter feeding the CI input FIFO.
// Round-robin grants on packet boundaries, registered write port.
module ts_ci_arb #(
  parameter int PKT_LEN = 188,
  parameter int CNT_W   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       en,
  input  logic [7:0]       s0_d,
  input  logic             s0_valid,
  input  logic             s0_start,
  output logic             s0_ready,
  input  logic [7:0]       s1_d,
  input  logic             s1_valid,
  input  logic             s1_start,
  output logic             s1_ready,
  output logic [7:0]       ts_ci_in_d,
  output logic             ts_ci_wrreq,
  output logic             pkt_start,
  input  logic             ts_ci_almost_full,
  output logic [CNT_W-1:0] pkts0,
  output logic [CNT_W-1:0] pkts1,
  output logic [15:0]      drops,
  output logic [15:0]      errs,
  output logic             busy
);

  localparam int CW = $clog2(PKT_LEN + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state, state_nx;
  logic          rr, rr_nx;
  logic          gnt, gnt_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic          c0, c1, win, win_vld;
  logic          g_valid, g_start;
  logic [7:0]    g_d;
  logic          af;

  logic          wr_nx, ps_nx;
  logic [7:0]    d_nx;
  logic          pk0_inc, pk1_inc, err_inc;
  logic          d0, d1;
  logic [1:0]    drop_n;
  logic [16:0]   drop_sum;

  assign af      = ts_ci_almost_full;
  assign c0      = en[0] & s0_valid & s0_start;
  assign c1      = en[1] & s1_valid & s1_start;
  assign win_vld = c0 | c1;
  // s1 wins only when it is the sole candidate or rr favours it
  assign win     = (c0 & c1) ? rr : c1;

  assign g_valid = gnt ? s1_valid : s0_valid;
  assign g_start = gnt ? s1_start : s0_start;
  assign g_d     = gnt ? s1_d     : s0_d;

  assign busy    = (state == XFER);

  always_comb begin
    state_nx = state;
    rr_nx    = rr;
    gnt_nx   = gnt;
    cnt_nx   = cnt;
    s0_ready = ~en[0];
    s1_ready = ~en[1];
    wr_nx    = 1'b0;
    ps_nx    = 1'b0;
    d_nx     = 8'h00;
    pk0_inc  = 1'b0;
    pk1_inc  = 1'b0;
    err_inc  = 1'b0;
    d0       = 1'b0;
    d1       = 1'b0;
    unique case (state)
      IDLE: begin
        // hunting for sync: non-start bytes are swallowed
        d0 = en[0] & s0_valid & ~s0_start;
        d1 = en[1] & s1_valid & ~s1_start;
        if (d0) s0_ready = 1'b1;
        if (d1) s1_ready = 1'b1;
        if (win_vld && !af) begin
          if (win) s1_ready = 1'b1;
          else     s0_ready = 1'b1;
          wr_nx    = 1'b1;
          ps_nx    = 1'b1;
          d_nx     = win ? s1_d : s0_d;
          cnt_nx   = CW'(1);
          gnt_nx   = win;
          rr_nx    = ~win;
          state_nx = XFER;
        end
      end
      XFER: begin
        if (gnt) s1_ready = ~af;
        else     s0_ready = ~af;
        if (g_valid && !af) begin
          wr_nx = 1'b1;
          d_nx  = g_d;
          if (g_start) begin
            err_inc = 1'b1;
            ps_nx   = 1'b1;
            cnt_nx  = CW'(1);
          end else if (cnt == CW'(PKT_LEN - 1)) begin
            pk0_inc  = ~gnt;
            pk1_inc  = gnt;
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
    endcase
  end

  assign drop_n   = {1'b0, d0} + {1'b0, d1};
  assign drop_sum = {1'b0, drops} + {15'd0, drop_n};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr          <= 1'b0;
      gnt         <= 1'b0;
      cnt         <= '0;
      ts_ci_wrreq <= 1'b0;
      pkt_start   <= 1'b0;
      ts_ci_in_d  <= 8'h00;
      pkts0       <= '0;
      pkts1       <= '0;
      drops       <= 16'h0000;
      errs        <= 16'h0000;
    end else begin
      state       <= state_nx;
      rr          <= rr_nx;
      gnt         <= gnt_nx;
      cnt         <= cnt_nx;
      ts_ci_wrreq <= wr_nx;
      pkt_start   <= ps_nx;
      ts_ci_in_d  <= d_nx;
      if (pk0_inc) pkts0 <= pkts0 + CNT_W'(1);
      if (pk1_inc) pkts1 <= pkts1 + CNT_W'(1);
      drops <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (err_inc && errs != 16'hFFFF) errs <= errs + 16'd1;
    end
  end

endmodule

// File: tb/tb_ts_ci_arb.sv
// Scoreboard bench for ts_ci_arb: directed packets, queued
// expected writes, negedge monitor.
module tb_ts_ci_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  en = 2'b11;
  logic [7:0]  s0_d = 8'h00, s1_d = 8'h00;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_start = 1'b0, s1_start = 1'b0;
  logic        s0_ready, s1_ready;
  logic [7:0]  ts_ci_in_d;
  logic        ts_ci_wrreq, pkt_start;
  logic        af = 1'b0;
  logic [23:0] pkts0, pkts1;
  logic [15:0] drops, errs;
  logic        busy;

  ts_ci_arb #(.PKT_LEN(188), .CNT_W(24)) dut (
    .clk(clk), .reset(reset), .en(en),
    .s0_d(s0_d), .s0_valid(s0_valid), .s0_start(s0_start),
    .s0_ready(s0_ready),
    .s1_d(s1_d), .s1_valid(s1_valid), .s1_start(s1_start),
    .s1_ready(s1_ready),
    .ts_ci_in_d(ts_ci_in_d), .ts_ci_wrreq(ts_ci_wrreq),
    .pkt_start(pkt_start), .ts_ci_almost_full(af),
    .pkts0(pkts0), .pkts1(pkts1), .drops(drops), .errs(errs),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int first_wr = 0;
  int last_wr = 0;
  int acc_first = 0;
  logic [8:0] exq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ts_ci_wrreq) begin
      if (wr_cnt == 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
      if (exq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got d=%0h ps=%0b, required none",
                 ts_ci_in_d, pkt_start);
      end else begin
        chk("wr_byte", 32'({pkt_start, ts_ci_in_d}),
            32'(exq.pop_front()));
      end
    end
  end

  function automatic logic [7:0] pb(input bit src, input int p,
                                    input int i);
    if (i == 0) return 8'h47;
    return 8'(i * 7 + p * 13 + (src ? 91 : 0));
  endfunction

  task automatic exp_pkt(input bit src, input int p);
    for (int i = 0; i < 188; i++)
      exq.push_back({(i == 0) ? 1'b1 : 1'b0, pb(src, p, i)});
  endtask

  task automatic set_src(input bit src, input logic v,
                         input logic [7:0] d, input logic st);
    if (src) begin
      s1_valid = v; s1_d = d; s1_start = st;
    end else begin
      s0_valid = v; s0_d = d; s0_start = st;
    end
  endtask

  task automatic send_byte(input bit src, input logic [7:0] d,
                           input logic st, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    set_src(src, 1'b1, d, st);
    #1;
    while (!(src ? s1_ready : s0_ready) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got no ready, required ready");
    end
    @(posedge clk);
    acc = cyc;
  endtask

  task automatic send_pkt(input bit src, input int p, input int af_at);
    int a;
    for (int i = 0; i < 188; i++) begin
      if (i == af_at) begin
        @(negedge clk);
        set_src(src, 1'b0, 8'h00, 1'b0);
        af = 1'b1;
        repeat (20) @(negedge clk);
        af = 1'b0;
      end
      send_byte(src, pb(src, p, i), (i == 0), a);
      if (i == 0) acc_first = a;
    end
    @(negedge clk);
    set_src(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(exq.size()), 32'd0);
    exq.delete();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_src(1'b0, 1'b0, 8'h00, 1'b0);
    set_src(1'b1, 1'b0, 8'h00, 1'b0);
    af = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_cnt = 0;
  endtask

  initial begin
    int a;
    do_reset();
    chk("rst_wrreq", 32'(ts_ci_wrreq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkts0", 32'(pkts0), 32'd0);
    chk("rst_drops", 32'(drops), 32'd0);

    // single packet, continuous valid
    exp_pkt(0, 0);
    send_pkt(0, 0, -1);
    drain();
    chk("t1_pkts0", 32'(pkts0), 32'd1);
    chk("t1_pkts1", 32'(pkts1), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_wr_cnt", 32'(wr_cnt), 32'd188);
    chk("t1_span", 32'(last_wr - first_wr), 32'd187);
    chk("t1_latency", 32'(first_wr - acc_first), 32'd1);

    // both sources contend, round-robin alternation
    do_reset();
    for (int p = 0; p < 4; p++) begin
      exp_pkt(0, p);
      exp_pkt(1, p);
    end
    fork
      for (int p = 0; p < 4; p++) send_pkt(0, p, -1);
      for (int q = 0; q < 4; q++) send_pkt(1, q, -1);
    join
    drain();
    chk("t2_pkts0", 32'(pkts0), 32'd4);
    chk("t2_pkts1", 32'(pkts1), 32'd4);
    chk("t2_wr_cnt", 32'(wr_cnt), 32'd1504);

    // almost-full stall at byte 100
    do_reset();
    exp_pkt(0, 2);
    send_pkt(0, 2, 100);
    drain();
    chk("t3_pkts0", 32'(pkts0), 32'd1);
    chk("t3_wr_cnt", 32'(wr_cnt), 32'd188);
    chk("t3_span", 32'(last_wr - first_wr), 32'd208);

    // garbage before sync
    do_reset();
    for (int k = 0; k < 5; k++) send_byte(0, 8'hA0 + 8'(k), 1'b0, a);
    exp_pkt(0, 3);
    send_pkt(0, 3, -1);
    drain();
    chk("t4_drops", 32'(drops), 32'd5);
    chk("t4_pkts0", 32'(pkts0), 32'd1);
    chk("t4_wr_cnt", 32'(wr_cnt), 32'd188);

    // early start at byte 50
    do_reset();
    for (int i = 0; i < 50; i++) begin
      exq.push_back({(i == 0) ? 1'b1 : 1'b0, pb(0, 9, i)});
      send_byte(0, pb(0, 9, i), (i == 0), a);
    end
    exp_pkt(0, 4);
    send_pkt(0, 4, -1);
    drain();
    chk("t5_errs", 32'(errs), 32'd1);
    chk("t5_pkts0", 32'(pkts0), 32'd1);
    chk("t5_wr_cnt", 32'(wr_cnt), 32'd238);

    // reset mid-packet at byte 90
    do_reset();
    for (int i = 0; i < 90; i++) begin
      exq.push_back({(i == 0) ? 1'b1 : 1'b0, pb(0, 5, i)});
      send_byte(0, pb(0, 5, i), (i == 0), a);
    end
    @(negedge clk);
    s0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_wrreq", 32'(ts_ci_wrreq), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_pkts0", 32'(pkts0), 32'd0);
    chk("t6_errs", 32'(errs), 32'd0);
    chk("t6_wr_cnt", 32'(wr_cnt), 32'd90);
    reset = 1'b0;
    wr_cnt = 0;
    exp_pkt(0, 6);
    send_pkt(0, 6, -1);
    drain();
    chk("t6_pkts0_after", 32'(pkts0), 32'd1);
    chk("t6_wr_cnt_after", 32'(wr_cnt), 32'd188);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_ci_arb.md
Name: ts_ci_arb

Overview:
- Two-source packet arbiter in front of the CI input FIFO. It merges two TS byte streams (tuner demod TS and USB host TS) into the single CI write port.
- Grants on 188-byte packet boundaries only, using round-robin priority, and honours the CI FIFO almost-full flag.
- Generates the pkt_start marker the CI FIFO stores alongside each byte. Keeps per-source packet, drop and error counters.

Parameters:
- PKT_LEN, 188, bytes per TS packet; grant is released after this many bytes.
- CNT_W, 24, width of the packet counters.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  2  per-source enable; bit0 = s0, bit1 = s1.
- s0_d  in  8  source 0 data byte.
- s0_valid  in  1  source 0 byte valid.
- s0_start  in  1  source 0 byte is 0x47 packet start.
- s0_ready  out  1  source 0 byte accepted this cycle (combinational).
- s1_d, s1_valid, s1_start, s1_ready  as for s0.
- ts_ci_in_d  out  8  byte to the CI FIFO (registered).
- ts_ci_wrreq  out  1  CI FIFO write strobe (registered).
- pkt_start  out  1  marks the first byte of a packet; aligned with ts_ci_wrreq.
- ts_ci_almost_full  in  1  CI FIFO almost-full flag.
- pkts0, pkts1  out  CNT_W  packets forwarded per source.
- drops  out  16  bytes discarded while hunting for sync; saturates at 0xFFFF.
- errs  out  16  packets truncated by an early start; saturates.
- busy  out  1  high while in XFER.

Behaviour:
- A byte transfers on a source when both valid and ready are high in the same cycle.
- Reset (synchronous, highest priority):
  - state goes to IDLE; rr = 0 (s0 preferred); byte count = 0.
  - ts_ci_wrreq, pkt_start, ts_ci_in_d, pkts0, pkts1, drops, errs and busy all = 0.
  - A packet in flight is abandoned; no further bytes are written.
- Output latency is 1 cycle: an accepted byte appears on ts_ci_in_d with ts_ci_wrreq = 1 in the next cycle. ts_ci_wrreq is 0 in every other cycle.
- A disabled source (en bit = 0) has ready = 1. Its bytes are discarded silently and are not counted.
- IDLE state:
  - Candidate source = enabled, valid and start all high.
  - If both sources are candidates, the one selected by rr wins.
  - When the winner exists and ts_ci_almost_full = 0: winner ready = 1 and its first byte is accepted in this cycle (no bubble). Output pkt_start = 1 for that byte. count = 1. Go to XFER with grant = winner. rr points to the other source.
  - When ts_ci_almost_full = 1: the winner's ready = 0 and it is held.
  - An enabled source with valid = 1 and start = 0 has ready = 1; the byte is discarded and drops increments.
- XFER state:
  - Granted source: ready = ~ts_ci_almost_full. Each accepted byte increments count.
  - Non-granted enabled source: ready = 0 (back-pressured, not dropped).
  - When the byte accepted with count = PKT_LEN-1 is taken, the packet is complete: increment pkts of the granted source, go to IDLE, count = 0. The next grant may start in the following cycle.
  - Early start (granted byte with start = 1 while 0 < count < PKT_LEN): errs increments. The byte is treated as a new packet start: pkt_start = 1, count = 1, grant is kept, and the truncated packet is not counted in pkts.
  - An en bit dropping during XFER does not abort the packet: the granted source keeps ready = ~ts_ci_almost_full until the packet completes, and rr updates as normal.
  - ts_ci_almost_full rising mid-packet stalls the packet (ready = 0, no writes) with no loss. Count is held.
- Counter arithmetic:
  - pkts wrap modulo 2^CNT_W.
  - drops and errs saturate.
  - count width is ceil(log2(PKT_LEN+1)).
- busy = 1 exactly while the state is XFER.

Test Plan:
- en=3, s0 sends one 188-byte packet (0x47, 1..187) with continuous valid:
  - 188 writes on consecutive cycles, first write 1 cycle after the first accept.
  - pkt_start only on 0x47; pkts0 = 1; busy returns to 0 after the last byte.
- Both sources present start in the same cycle, 4 packets each:
  - Write order s0, s1, s0, s1, ...
  - pkts0 = pkts1 = 4; no interleaving within any packet.
- Hold ts_ci_almost_full = 1 for 20 cycles at byte 100:
  - No writes during the hold; the stream resumes at byte 100.
  - Exactly 188 writes total, data intact.
- s0 sends 5 garbage bytes, then a valid packet:
  - drops = 5, the 5 bytes are never written, and the packet is forwarded whole.
- s0 sends a start at byte 50 of a packet:
  - errs = 1, pkt_start pulses on the second 0x47.
  - pkts0 counts only the completed packet.
- Assert reset at byte 90:
  - The next cycle has wrreq = 0, all counters = 0, busy = 0.
  - After release, a fresh packet forwards normally with pkts0 = 1.
